// File: rtl/ttt_button_conditioner.sv
// Tic-tac-toe button front end.
// Nine square buttons and a start button are each synchronised and debounced.
// Accepted square presses become a single registered one-hot move pulse.
// Further presses are locked out until every square reads released again.
// The start button yields its own registered rising-edge pulse.

// One input lane: 2-FF synchroniser followed by a stable-count debouncer.
// The level flips only after DB_CYCLES consecutive samples disagree with it.
// DB_CYCLES must be >= 2 so the counter is at least one bit wide.
module ttt_btn_lane #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int              CW       = $clog2(DB_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Two-stage synchroniser for the asynchronous raw input
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= '0;
    else        sync <= {sync[0], raw};
  end

  // Count consecutive disagreeing samples; toggle the level on the last one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync[1] != level) begin
      if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

module ttt_button_conditioner #(
  parameter int NUM_BTN   = 9,
  parameter int DB_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               start_raw,
  input  logic               enable,
  output logic               move_valid,
  output logic [NUM_BTN-1:0] move_onehot,
  output logic [3:0]         move_idx,
  output logic               start_pulse,
  output logic [NUM_BTN-1:0] btn_level
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state, state_nx;
  logic [NUM_BTN-1:0] level_q;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] pick;
  logic               start_level, start_level_q, start_rise;
  logic               mv_nx;
  logic [NUM_BTN-1:0] oh_nx;
  logic [3:0]         idx_nx;

  // One debouncer lane per square button
  generate
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_lane
      ttt_btn_lane #(.DB_CYCLES(DB_CYCLES)) u_lane (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_raw[g]),
        .level (btn_level[g])
      );
    end
  endgenerate

  ttt_btn_lane #(.DB_CYCLES(DB_CYCLES)) u_start (
    .clk   (clk),
    .reset (reset),
    .raw   (start_raw),
    .level (start_level)
  );

  // Delayed debounced levels for rising-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q       <= '0;
      start_level_q <= 1'b0;
    end else begin
      level_q       <= btn_level;
      start_level_q <= start_level;
    end
  end

  assign rise       = btn_level & ~level_q;
  assign start_rise = start_level & ~start_level_q;
  // Isolate the lowest set bit: simultaneous presses resolve to the lowest square
  assign pick       = rise & (~rise + NUM_BTN'(1));

  // Next state and next registered outputs of the lockout FSM
  always_comb begin
    state_nx = state;
    mv_nx    = 1'b0;
    oh_nx    = '0;
    idx_nx   = '0;
    case (state)
      IDLE: begin
        if (|rise) begin
          // A rise always arms the lockout, even when the move is suppressed
          state_nx = HOLD;
          if (enable) begin
            mv_nx = 1'b1;
            oh_nx = pick;
            for (int i = 0; i < NUM_BTN; i++)
              if (pick[i]) idx_nx = 4'(i);
          end
        end
      end
      HOLD: begin
        if (btn_level == '0) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register and glitch-free registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      move_valid  <= 1'b0;
      move_onehot <= '0;
      move_idx    <= '0;
      start_pulse <= 1'b0;
    end else begin
      state       <= state_nx;
      move_valid  <= mv_nx;
      move_onehot <= oh_nx;
      move_idx    <= idx_nx;
      start_pulse <= start_rise;
    end
  end

endmodule

// File: tb/tb_ttt_button_conditioner.sv
// Scoreboard bench for ttt_button_conditioner with DB_CYCLES=4.
// Stimulus pushes the expected pulse cycle and square; a negedge monitor pops
// and compares whenever the DUT pulses, and flags pulses that never arrive.
module tb_ttt_button_conditioner;

  localparam int NB  = 9;
  localparam int DB  = 4;
  localparam int LAT = DB + 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic          start_raw;
  logic          enable;
  logic          move_valid;
  logic [NB-1:0] move_onehot;
  logic [3:0]    move_idx;
  logic          start_pulse;
  logic [NB-1:0] btn_level;

  typedef struct {
    int         cyc;
    logic [3:0] idx;
  } exp_t;

  exp_t move_q[$];
  int   start_q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_err  = 0;

  ttt_button_conditioner #(.NUM_BTN(NB), .DB_CYCLES(DB)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .start_raw   (start_raw),
    .enable      (enable),
    .move_valid  (move_valid),
    .move_onehot (move_onehot),
    .move_idx    (move_idx),
    .start_pulse (start_pulse),
    .btn_level   (btn_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_move(input int idx);
    exp_t e;
    e.cyc = cyc + LAT;
    e.idx = 4'(idx);
    move_q.push_back(e);
  endtask

  // Monitor: compare every pulse against the scoreboard, sampled at negedge
  always @(negedge clk) begin
    if (move_valid) begin
      if (move_q.size() == 0) begin
        chk("move_unexpected", {28'd0, move_idx}, 32'hFFFF);
      end else begin
        exp_t e;
        logic [NB-1:0] oh;
        e  = move_q.pop_front();
        oh = NB'(1) << e.idx;
        chk("move_cyc", cyc, e.cyc);
        chk("move_idx", {28'd0, move_idx}, {28'd0, e.idx});
        chk("move_onehot", {23'd0, move_onehot}, {23'd0, oh});
      end
    end else begin
      chk("move_idle", {19'd0, move_idx, move_onehot}, 32'd0);
    end
    while (move_q.size() > 0 && move_q[0].cyc < cyc) begin
      chk("move_missed", cyc, move_q[0].cyc);
      void'(move_q.pop_front());
    end
    if (start_pulse) begin
      if (start_q.size() == 0) chk("start_unexpected", 1, 0);
      else                     chk("start_cyc", cyc, start_q.pop_front());
    end
    while (start_q.size() > 0 && start_q[0] < cyc) begin
      chk("start_missed", cyc, start_q[0]);
      void'(start_q.pop_front());
    end
  end

  // Watchdog so the run always ends
  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    btn_raw   = '0;
    start_raw = 1'b0;
    enable    = 1'b1;

    // 1: reset low 3 cycles, outputs zero during and after
    wait_cyc(3);
    chk("rst_outs_low", {20'd0, move_valid, start_pulse, btn_level, move_onehot != 0}, 32'd0);
    reset = 1'b1;
    wait_cyc(3);
    chk("rst_outs_after", {21'd0, move_valid, start_pulse, btn_level}, 32'd0);

    // 2: single press on square 4
    btn_raw = 9'h010;
    exp_move(4);
    wait_cyc(10);
    chk("lvl_sq4", {23'd0, btn_level}, 32'h010);
    wait_cyc(10);
    btn_raw = '0;
    wait_cyc(12);
    chk("lvl_rel2", {23'd0, btn_level}, 32'd0);

    // 3: bounce on square 2 (max 2-sample runs), then a clean hold
    for (int k = 0; k < 30; k++) begin
      btn_raw[2] = ((k / 2) % 2) == 1;
      wait_cyc(1);
    end
    chk("lvl_bounce", {23'd0, btn_level}, 32'd0);
    btn_raw[2] = 1'b1;
    exp_move(2);
    wait_cyc(10);
    btn_raw = '0;
    wait_cyc(12);

    // 4: simultaneous 5 and 7, partial release, then fresh press of 7
    btn_raw = 9'h0A0;
    exp_move(5);
    wait_cyc(12);
    btn_raw = 9'h080;
    wait_cyc(12);
    chk("lvl_hold7", {23'd0, btn_level}, 32'h080);
    btn_raw = '0;
    wait_cyc(12);
    btn_raw = 9'h080;
    exp_move(7);
    wait_cyc(12);
    btn_raw = '0;
    wait_cyc(12);

    // 5: press while disabled, enable while held, then re-press
    enable  = 1'b0;
    btn_raw = 9'h001;
    wait_cyc(12);
    enable = 1'b1;
    wait_cyc(12);
    btn_raw = '0;
    wait_cyc(12);
    btn_raw = 9'h001;
    exp_move(0);
    wait_cyc(12);
    btn_raw = '0;
    wait_cyc(12);

    // 6: start and square 8 together pulse on the same cycle
    start_raw = 1'b1;
    btn_raw   = 9'h100;
    exp_move(8);
    start_q.push_back(cyc + LAT);
    wait_cyc(12);
    start_raw = 1'b0;
    btn_raw   = '0;
    wait_cyc(12);

    // Repeat, but drop reset mid-debounce: no pulses at all
    start_raw = 1'b1;
    btn_raw   = 9'h100;
    wait_cyc(3);
    reset     = 1'b0;
    start_raw = 1'b0;
    btn_raw   = '0;
    wait_cyc(1);
    chk("rst_mid_outs", {21'd0, move_valid, start_pulse, btn_level}, 32'd0);
    wait_cyc(2);
    reset = 1'b1;
    wait_cyc(15);
    chk("lvl_after_rst", {23'd0, btn_level}, 32'd0);

    // Button held across reset release: normal latency from release
    reset   = 1'b0;
    btn_raw = 9'h008;
    wait_cyc(3);
    reset = 1'b1;
    exp_move(3);
    wait_cyc(12);

    // Reset during HOLD with release: lockout cleared, next press accepted
    reset   = 1'b0;
    btn_raw = '0;
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(3);
    btn_raw = 9'h040;
    exp_move(6);
    wait_cyc(12);
    btn_raw = '0;
    wait_cyc(12);

    chk("move_q_left", move_q.size(), 0);
    chk("start_q_left", start_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
